// File: rtl/alu_pkg.sv
// alu_pkg: opcodes shared with the ALU and the arbiter FSM state encoding
package alu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;
    typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_RESP} arb_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant, first requester at or above ptr wins
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IW-1:0]      gnt_idx
);
    int idx;
    // Scan farthest-first so the nearest requester above ptr is the last write
    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        idx = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                gnt = NUM_REQ'(1) << idx;
                gnt_idx = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one sequenced ALU among NUM_REQ requesters, round-robin,
// one operation in flight, with a done watchdog that aborts after TIMEOUT wait cycles.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [2*NUM_REQ-1:0]     req_opcode,
    input  logic [WIDTH*NUM_REQ-1:0] req_x,
    input  logic [WIDTH*NUM_REQ-1:0] req_y,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [2*WIDTH-1:0]       rsp_result,
    output logic                     rsp_timeout,
    output logic                     alu_start,
    output logic [1:0]               alu_opcode,
    output logic [WIDTH-1:0]         alu_x,
    output logic [WIDTH-1:0]         alu_y,
    input  logic                     alu_done,
    input  logic [2*WIDTH-1:0]       alu_result,
    output logic                     busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    arb_state_e          state, state_nx;
    logic [IW-1:0]       ptr, g_idx, gnt_idx;
    logic [NUM_REQ-1:0]  gnt;
    logic [CW-1:0]       cnt;
    logic                accept, rsp_fire, expired;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign accept    = state == ARB_IDLE && |req_valid;
    assign rsp_fire  = state == ARB_RESP && rsp_ready[g_idx];
    // cnt counts completed WAIT cycles, so this is the TIMEOUT-th WAIT cycle
    assign expired   = cnt == CW'(TIMEOUT - 1);
    assign req_ready = (state == ARB_IDLE && reset) ? gnt : '0;
    assign rsp_valid = (state == ARB_RESP) ? NUM_REQ'(1) << g_idx : '0;
    assign alu_start = state == ARB_ISSUE;
    assign busy      = state != ARB_IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            ARB_IDLE:  state_nx = accept ? ARB_ISSUE : ARB_IDLE;
            ARB_ISSUE: state_nx = ARB_WAIT;
            ARB_WAIT:  state_nx = (alu_done || expired) ? ARB_RESP : ARB_WAIT;
            ARB_RESP:  state_nx = rsp_fire ? ARB_IDLE : ARB_RESP;
            default:   state_nx = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ARB_IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr         <= '0;
            g_idx       <= '0;
            alu_opcode  <= '0;
            alu_x       <= '0;
            alu_y       <= '0;
            cnt         <= '0;
            rsp_result  <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                g_idx      <= gnt_idx;
                alu_opcode <= req_opcode[2*gnt_idx +: 2];
                alu_x      <= req_x[WIDTH*gnt_idx +: WIDTH];
                alu_y      <= req_y[WIDTH*gnt_idx +: WIDTH];
            end
            cnt <= (state == ARB_WAIT) ? cnt + CW'(1) : '0;
            // done takes priority over a coinciding watchdog expiry
            if (state == ARB_WAIT && (alu_done || expired)) begin
                rsp_result  <= alu_done ? alu_result : '0;
                rsp_timeout <= !alu_done;
            end
            if (rsp_fire)
                ptr <= (g_idx == IW'(NUM_REQ - 1)) ? '0 : g_idx + IW'(1);
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scenario tasks with a response scoreboard and a behavioural ALU
// that answers alu_start after a programmable number of cycles.
module tb_alu_arbiter;
    import alu_pkg::*;
    localparam int N = 2, W = 8, TO = 63;

    logic clk = 1'b0, reset = 1'b0;
    logic [N-1:0] req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
    logic [2*N-1:0] req_opcode = '0;
    logic [W*N-1:0] req_x = '0, req_y = '0;
    logic [2*W-1:0] rsp_result, alu_result;
    logic rsp_timeout, alu_start, alu_done, busy;
    logic [1:0] alu_opcode;
    logic [W-1:0] alu_x, alu_y;

    typedef struct { int idx; logic [15:0] res; logic to; } exp_t;
    exp_t exp_q[$];
    int tests = 0, fails = 0, cyc = 0, start_cnt = 0, start_cyc = 0;
    int rsp_cyc = 0, acc_cyc = 0, done_delay = 0, exp_ptr = 0;

    alu_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
        .alu_start(alu_start), .alu_opcode(alu_opcode), .alu_x(alu_x), .alu_y(alu_y),
        .alu_done(alu_done), .alu_result(alu_result), .busy(busy)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected $finish");
        $fatal(1);
    end

    function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [7:0] x, input logic [7:0] y);
        logic signed [15:0] a, b;
        a = {{8{x[7]}}, x};
        b = {{8{y[7]}}, y};
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_MUL: return a * b;
            default: return (y == 0) ? 16'hFFFF : {x % y, x / y};
        endcase
    endfunction

    // Behavioural ALU: done pulse in cycle start+done_delay; done_delay<=0 never answers
    initial begin : alu_model
        int cd;
        logic [15:0] m_res;
        logic [17:0] snap;
        cd = 0; m_res = '0; snap = '0;
        alu_done = 1'b0;
        alu_result = 16'hDEAD;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            alu_result = 16'hDEAD;
            if (!reset) cd = 0;
            else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        alu_done = 1'b1;
                        alu_result = m_res;
                        tests++;
                        if ({alu_opcode, alu_x, alu_y} !== snap) begin
                            fails++;
                            $display("FAIL operand_hold: got %h expected %h", {alu_opcode, alu_x, alu_y}, snap);
                        end
                    end
                end
                if (alu_start) begin
                    start_cnt++;
                    start_cyc = cyc;
                    snap = {alu_opcode, alu_x, alu_y};
                    m_res = alu_ref(alu_opcode, alu_x, alu_y);
                    cd = (done_delay > 0) ? done_delay : 0;
                end
            end
        end
    end

    task automatic push_exp(input int idx, input logic [15:0] res, input logic to);
        exp_t e;
        e.idx = idx; e.res = res; e.to = to;
        exp_q.push_back(e);
    endtask

    // Raise a request, wait for its grant, record expectation, drop it after accept
    task automatic send(input int idx, input logic [1:0] op, input logic [7:0] x, input logic [7:0] y,
                        input int delay, input logic to);
        logic [N-1:0] oh;
        done_delay = delay;
        req_opcode[2*idx +: 2] = op;
        req_x[W*idx +: W] = x;
        req_y[W*idx +: W] = y;
        req_valid[idx] = 1'b1;
        for (int n = 0; n < 80; n++) begin
            #1;
            if (req_ready[idx]) break;
            @(negedge clk);
        end
        oh = N'(1) << idx;
        tests++;
        if (req_ready !== oh) begin
            fails++;
            $display("FAIL grant_req%0d: req_ready=%b expected %b", idx, req_ready, oh);
        end
        acc_cyc = cyc;
        push_exp(idx, to ? 16'h0000 : alu_ref(op, x, y), to);
        @(negedge clk);
        req_valid[idx] = 1'b0;
    endtask

    // Wait for a response and compare it with the scoreboard head
    task automatic check_rsp(input int budget);
        exp_t e;
        logic [N-1:0] oh;
        for (int n = 0; n < budget; n++) begin
            #1;
            if (rsp_valid != '0) break;
            @(negedge clk);
        end
        rsp_cyc = cyc;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard: got response %b expected none pending", rsp_valid);
            return;
        end
        e = exp_q.pop_front();
        oh = N'(1) << e.idx;
        if (rsp_valid !== oh) begin
            fails++;
            $display("FAIL rsp_valid: got %b expected %b", rsp_valid, oh);
        end
        tests += 2;
        if (rsp_result !== e.res) begin
            fails++;
            $display("FAIL rsp_result: got %h expected %h", rsp_result, e.res);
        end
        if (rsp_timeout !== e.to) begin
            fails++;
            $display("FAIL rsp_timeout: got %b expected %b", rsp_timeout, e.to);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = '1;
        rsp_ready = '1;
        repeat (3) @(negedge clk);
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_result, rsp_timeout, alu_start, alu_opcode, alu_x, alu_y, busy} !== 41'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req_ready, rsp_valid, rsp_result, rsp_timeout, alu_start, alu_opcode, alu_x, alu_y, busy});
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '0;
        reset = 1'b1;
        exp_ptr = 0;
    endtask

    task automatic test_round_robin();
        logic [N-1:0] oh;
        req_opcode = {OP_ADD, OP_ADD};
        req_x = {8'h7F, 8'h10};
        req_y = {8'h01, 8'h22};
        done_delay = 2;
        rsp_ready = '1;
        req_valid = '1;
        for (int k = 0; k < 4; k++) begin
            for (int n = 0; n < 20; n++) begin
                #1;
                if (req_ready != '0) break;
                @(negedge clk);
            end
            oh = N'(1) << exp_ptr;
            tests++;
            if (req_ready !== oh) begin
                fails++;
                $display("FAIL rr_grant%0d: req_ready=%b expected %b", k, req_ready, oh);
            end
            push_exp(exp_ptr, alu_ref(OP_ADD, req_x[W*exp_ptr +: W], req_y[W*exp_ptr +: W]), 1'b0);
            @(negedge clk);
            check_rsp(20);
            exp_ptr = (exp_ptr + 1) % N;
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = '0;
    endtask

    task automatic test_single_mul();
        int s0;
        s0 = start_cnt;
        send(0, OP_MUL, 8'd5, 8'hFD, 9, 1'b0);
        #1;
        tests += 2;
        if (alu_start !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL issue_start: got start=%b busy=%b expected 1 1", alu_start, busy);
        end
        if ({alu_opcode, alu_x, alu_y} !== {OP_MUL, 8'd5, 8'hFD}) begin
            fails++;
            $display("FAIL issue_operands: got %h expected %h", {alu_opcode, alu_x, alu_y}, {OP_MUL, 8'd5, 8'hFD});
        end
        rsp_ready[0] = 1'b1;
        check_rsp(40);
        tests++;
        if (rsp_cyc - start_cyc !== 10) begin
            fails++;
            $display("FAIL mul_latency: got %0d expected 10", rsp_cyc - start_cyc);
        end
        @(negedge clk);
        #1;
        tests += 2;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_rsp: got %b expected 0", busy);
        end
        if (start_cnt - s0 !== 1) begin
            fails++;
            $display("FAIL start_count: got %0d expected 1", start_cnt - s0);
        end
        rsp_ready = '0;
        exp_ptr = 1;
    endtask

    task automatic test_timeout();
        logic bad;
        rsp_ready[exp_ptr] = 1'b1;
        send(exp_ptr, OP_DIV, 8'd50, 8'd7, 70, 1'b1);
        check_rsp(100);
        tests++;
        if (rsp_cyc - start_cyc !== TO + 1) begin
            fails++;
            $display("FAIL timeout_latency: got %0d expected %0d", rsp_cyc - start_cyc, TO + 1);
        end
        exp_ptr = (exp_ptr + 1) % N;
        bad = 1'b0;
        @(negedge clk);
        repeat (10) begin
            #1;
            if (rsp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL late_done: got activity after late done expected idle");
        end
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        int other;
        logic [15:0] r0;
        logic [N-1:0] oh;
        logic bad;
        other = exp_ptr ^ 1;
        rsp_ready = '0;
        send(exp_ptr, OP_SUB, 8'd9, 8'd5, 3, 1'b0);
        done_delay = 2;
        req_opcode[2*other +: 2] = OP_ADD;
        req_x[W*other +: W] = 8'd3;
        req_y[W*other +: W] = 8'd4;
        req_valid[other] = 1'b1;
        check_rsp(20);
        r0 = rsp_result;
        oh = N'(1) << exp_ptr;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (rsp_result !== r0 || rsp_valid !== oh || req_ready !== '0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL backpressure_hold: got result=%h valid=%b ready=%b expected %h %b 0",
                     rsp_result, rsp_valid, req_ready, r0, oh);
        end
        @(negedge clk);
        rsp_ready[exp_ptr] = 1'b1;
        @(negedge clk);
        #1;
        oh = N'(1) << other;
        tests++;
        if (req_ready !== oh) begin
            fails++;
            $display("FAIL grant_after_handshake: got %b expected %b", req_ready, oh);
        end
        push_exp(other, alu_ref(OP_ADD, 8'd3, 8'd4), 1'b0);
        @(negedge clk);
        req_valid[other] = 1'b0;
        rsp_ready = '0;
        rsp_ready[other] = 1'b1;
        check_rsp(20);
        @(negedge clk);
        rsp_ready = '0;
        exp_ptr = (other + 1) % N;
    endtask

    task automatic test_reset_mid_wait();
        rsp_ready = '1;
        send(exp_ptr, OP_ADD, 8'h01, 8'h01, 1, 1'b0);
        check_rsp(20);
        @(negedge clk);
        exp_ptr = (exp_ptr + 1) % N;
        send(exp_ptr, OP_MUL, 8'h0C, 8'h0C, -1, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if ({req_ready, rsp_valid, rsp_result, rsp_timeout, alu_start, alu_opcode, alu_x, alu_y, busy} !== 41'b0) begin
            fails++;
            $display("FAIL reset_mid_wait: got %h expected 0",
                     {req_ready, rsp_valid, rsp_result, rsp_timeout, alu_start, alu_opcode, alu_x, alu_y, busy});
        end
        exp_q.delete();
        req_opcode = {OP_SUB, OP_ADD};
        req_x = {8'h20, 8'h40};
        req_y = {8'h10, 8'h02};
        req_valid = '1;
        done_delay = 1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (req_ready !== 2'b01) begin
            fails++;
            $display("FAIL grant_after_reset: got %b expected 01", req_ready);
        end
        push_exp(0, alu_ref(OP_ADD, 8'h40, 8'h02), 1'b0);
        @(negedge clk);
        req_valid = '0;
        check_rsp(20);
        @(negedge clk);
        rsp_ready = '0;
        exp_ptr = 1;
    endtask

    task automatic test_done_timeout_coincide();
        rsp_ready[exp_ptr] = 1'b1;
        send(exp_ptr, OP_DIV, 8'd200, 8'd7, TO, 1'b0);
        check_rsp(100);
        tests++;
        if (rsp_cyc - start_cyc !== TO + 1) begin
            fails++;
            $display("FAIL coincide_latency: got %0d expected %0d", rsp_cyc - start_cyc, TO + 1);
        end
        @(negedge clk);
        rsp_ready = '0;
        exp_ptr = (exp_ptr + 1) % N;
    endtask

    task automatic test_back_to_back();
        int r;
        rsp_ready = '1;
        send(0, OP_ADD, 8'h05, 8'h06, 1, 1'b0);
        check_rsp(10);
        tests++;
        if (rsp_cyc - acc_cyc !== 3) begin
            fails++;
            $display("FAIL turnaround: got %0d expected 3", rsp_cyc - acc_cyc);
        end
        r = rsp_cyc;
        send(1, OP_SUB, 8'h03, 8'h08, 1, 1'b0);
        tests++;
        if (acc_cyc !== r + 1) begin
            fails++;
            $display("FAIL b2b_accept: got cycle %0d expected %0d", acc_cyc, r + 1);
        end
        check_rsp(10);
        @(negedge clk);
        rsp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_mul();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_done_timeout_coincide();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer and arbiter that shares the single 8-bit ALU (sequenced by its control unit: add, subtract, Booth multiply, restoring divide) among `NUM_REQ` requesters. It accepts one operation at a time through a valid/ready request port and grants requesters in round-robin order. It issues a one-cycle `start` to the ALU, holds operands stable, and waits for the ALU's `done`, guarded by a timeout watchdog. It returns the 16-bit result to the granted requester on a valid/ready response port.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..4.
- `WIDTH`, default 8: operand width; the result is `2*WIDTH`.
- `TIMEOUT`, default 63: the maximum number of WAIT cycles before the operation is aborted; must be ≥ 1.
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low.
- `req_valid` input, `NUM_REQ` bits: request pending, one bit per requester.
- `req_ready` output, `NUM_REQ` bits: one-hot grant/accept strobe.
- `req_opcode` input, `2*NUM_REQ` bits: opcode for each requester; requester i uses bits [2i+1:2i]. Encoding: 00 add, 01 sub, 10 mul, 11 div.
- `req_x` input, `WIDTH*NUM_REQ` bits: operand X for each requester, packed the same way.
- `req_y` input, `WIDTH*NUM_REQ` bits: operand Y for each requester, packed the same way.
- `rsp_valid` output, `NUM_REQ` bits: one-hot response valid.
- `rsp_ready` input, `NUM_REQ` bits: response accepted, one bit per requester.
- `rsp_result` output, `2*WIDTH` bits: the result.
- `rsp_timeout` output, 1 bit: the response is a timeout abort.
- `alu_start` output, 1 bit: one-cycle start pulse to the ALU control unit.
- `alu_opcode` output, 2 bits: opcode driven to the ALU.
- `alu_x` output, `WIDTH` bits: operand X driven to the ALU.
- `alu_y` output, `WIDTH` bits: operand Y driven to the ALU.
- `alu_done` input, 1 bit: ALU completion pulse.
- `alu_result` input, `2*WIDTH` bits: ALU result, valid in the cycle `alu_done` is high.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- State machine: IDLE → ISSUE → WAIT → RESP → IDLE.
- **IDLE**
  - If any `req_valid` is set, `req_ready[g]` goes high combinationally for the granted index g.
  - g is the first set bit of `req_valid` searching upward from pointer `ptr`, wrapping modulo `NUM_REQ`.
  - On `req_valid[g] & req_ready[g]`: latch g, the opcode and both operands into holding registers, then go to ISSUE.
- **ISSUE**
  - `alu_start` = 1 for exactly one cycle.
  - `alu_opcode`, `alu_x` and `alu_y` are driven from the holding registers.
  - Clear the watchdog counter, then go to WAIT.
- **WAIT**
  - Operands stay stable; the watchdog counter increments each cycle.
  - On `alu_done`: latch `alu_result`, set `rsp_timeout` = 0, go to RESP.
  - When the counter equals `TIMEOUT` and `alu_done` is low: set result = 0, set `rsp_timeout` = 1, go to RESP.
  - If `alu_done` and the timeout coincide, `done` wins.
- **RESP**
  - `rsp_valid[g]` = 1 and `rsp_result` is held until `rsp_ready[g]`.
  - On that handshake: set `ptr` = (g+1) mod `NUM_REQ` and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- `alu_done` outside WAIT is ignored; this includes a late `done` after a timeout.
- Requests arriving in a non-IDLE state wait with `req_ready` = 0; requesters must hold `req_valid` and the request data stable until accepted.
- Only one operation is in flight at a time; there is no queueing.

## Timing
- Reset (asynchronous, `reset` = 0):
  - State = IDLE and `ptr` = 0.
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_result`, `rsp_timeout`, `alu_start`, `alu_opcode`, `alu_x`, `alu_y`, `busy`.
- Reset asserted mid-operation aborts the operation with no response; the ALU is reset by the same signal.
- Latency, with the accept cycle as T:
  - `alu_start` is high in T+1.
  - If `alu_done` arrives in cycle D, `rsp_valid` is high from D+1.
  - Minimum turnaround from accept to response is therefore 3 cycles.
- Timeout: `rsp_valid` rises `TIMEOUT`+1 cycles after the `alu_start` cycle.
- `busy` = 1 from T+1 until the cycle after the response handshake.
- Back-to-back operation: after a RESP handshake in cycle R, a new request can be accepted in cycle R+1.
- All outputs except `req_ready` are registered; `req_ready` is decoded from state and `req_valid`.

## Structure
- Shared package `alu_pkg`:
  - Opcode constants `OP_ADD` = 00, `OP_SUB` = 01, `OP_MUL` = 10, `OP_DIV` = 11.
  - State encoding `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`.
- Sub-module `rr_arbiter`:
  - Combinational round-robin grant.
  - Inputs: `req[NUM_REQ]` and `ptr`.
  - Outputs: one-hot `gnt` and encoded `gnt_idx`.
- The FSM, holding registers and watchdog live in `alu_arbiter`.

## Test plan
- Single mul request: requester 0 sends mul 5 × (−3); ALU model asserts done 9 cycles after start → `rsp_valid[0]` with `rsp_result` = 16'hFFF1, `rsp_timeout` = 0, and `alu_start` seen exactly once.
- Round-robin fairness: both requesters hold `req_valid` continuously with add ops → grants alternate 0, 1, 0, 1, and `ptr` advances after each response.
- Timeout: with `TIMEOUT` = 63 the ALU never asserts done → response in the 64th cycle after start with result 0 and `rsp_timeout` = 1; a later spurious `alu_done` is ignored.
- Response backpressure: `rsp_ready` held low 5 cycles → `rsp_result` is stable, `req_ready` = 0 for the other requester, and a grant is issued the cycle after the handshake.
- Reset mid-WAIT: `reset` pulled low 3 cycles after start → all outputs are 0 immediately, and the first request after release is granted to requester 0.
- Simultaneous `alu_done` and timeout in the same cycle → `rsp_timeout` = 0 and the ALU result is returned.
